// File: rtl/squash_unit_l1_chain.sv
// Squash arbiter: forwards the oldest of p_num_arb squash requests, with age taken relative to the tracked commit head.
// Optional build macro SQUASH_UNIT_L1_CHAIN_TRACE_EN adds a trace(level) string renderer.
module squash_unit_l1_chain #(
  parameter int p_num_arb      = 2,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [p_num_arb-1:0]                      arb_val,
  input  logic [p_num_arb-1:0][p_seq_num_bits-1:0]  arb_seq_num,
  input  logic [p_num_arb-1:0][31:0]                arb_target,
  output logic                                      gnt_val,
  output logic [p_seq_num_bits-1:0]                 gnt_seq_num,
  output logic [31:0]                               gnt_target,
  input  logic                                      commit_val,
  input  logic [31:0]                               commit_pc,
  input  logic [p_seq_num_bits-1:0]                 commit_seq_num,
  input  logic [4:0]                                commit_waddr,
  input  logic [31:0]                               commit_wdata,
  input  logic                                      commit_wen
);

  typedef logic [p_seq_num_bits-1:0] seq_t;

  seq_t head;
  logic unused_commit_fields;

  // Only the commit point matters here; the rest of the commit record is ignored.
  assign unused_commit_fields = ^{commit_pc, commit_waddr, commit_wdata, commit_wen};

  function automatic seq_t age(input seq_t s, input seq_t h);
    return seq_t'(s - h);
  endfunction

  function automatic logic is_older(input seq_t a, input seq_t b, input seq_t h);
    return age(a, h) < age(b, h);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      head <= '0;
    else if (commit_val)
      head <= commit_seq_num + seq_t'(1);
  end

  // Strict compare keeps the earlier index on equal ages, so ties go to the lower requester.
  always_comb begin
    gnt_val     = 1'b0;
    gnt_seq_num = '0;
    gnt_target  = '0;
    for (int i = 0; i < p_num_arb; i++) begin
      if (arb_val[i] && (!gnt_val || is_older(arb_seq_num[i], gnt_seq_num, head))) begin
        gnt_val     = 1'b1;
        gnt_seq_num = arb_seq_num[i];
        gnt_target  = arb_target[i];
      end
    end
  end

`ifdef SQUASH_UNIT_L1_CHAIN_TRACE_EN
  function automatic string trace(int level);
    string s;
    string blank;
    s     = "";
    blank = "";
    for (int k = 0; k < (p_seq_num_bits + 3) / 4 + 9; k++)
      blank = {blank, " "};
    for (int i = 0; i < p_num_arb; i++) begin
      if (i > 0)
        s = {s, " "};
      if (arb_val[i])
        s = {s, $sformatf("%h:%h", arb_seq_num[i], arb_target[i])};
      else
        s = {s, blank};
    end
    s = {s, " > "};
    if (gnt_val)
      s = {s, $sformatf("%h:%h", gnt_seq_num, gnt_target)};
    else
      s = {s, blank};
    if (level > 1)
      s = {s, $sformatf(" head=%h", head)};
    return s;
  endfunction
`endif

endmodule

// File: tb/tb_squash_unit_l1_chain.sv
// Self-checking bench for squash_unit_l1_chain: directed cases on small configurations plus randomized rounds on a 20-requester build.
module tb_squash_unit_l1_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] c_pc = 32'h0000_1000;
  logic [4:0]  c_waddr = 5'd3;
  logic [31:0] c_wdata = 32'hDEAD_BEEF;
  logic        c_wen = 1'b1;

  // Instance A: 4 requesters, 5-bit sequence numbers
  logic [3:0]       a_val = '0;
  logic [3:0][4:0]  a_seq = '0;
  logic [3:0][31:0] a_tgt = '0;
  logic             a_gval;
  logic [4:0]       a_gseq;
  logic [31:0]      a_gtgt;
  logic             a_cval = 1'b0;
  logic [4:0]       a_cseq = '0;

  // Instance B: 2 requesters, 3-bit sequence numbers
  logic [1:0]       b_val = '0;
  logic [1:0][2:0]  b_seq = '0;
  logic [1:0][31:0] b_tgt = '0;
  logic             b_gval;
  logic [2:0]       b_gseq;
  logic [31:0]      b_gtgt;
  logic             b_cval = 1'b0;
  logic [2:0]       b_cseq = '0;

  // Instance C: 20 requesters, 6-bit sequence numbers
  logic [19:0]       c_val = '0;
  logic [19:0][5:0]  c_seq = '0;
  logic [19:0][31:0] c_tgt = '0;
  logic              c_gval;
  logic [5:0]        c_gseq;
  logic [31:0]       c_gtgt;
  logic              c_cval = 1'b0;
  logic [5:0]        c_cseq = '0;

  squash_unit_l1_chain #(.p_num_arb(4), .p_seq_num_bits(5)) dut_a (
    .clk(clk), .rst(rst),
    .arb_val(a_val), .arb_seq_num(a_seq), .arb_target(a_tgt),
    .gnt_val(a_gval), .gnt_seq_num(a_gseq), .gnt_target(a_gtgt),
    .commit_val(a_cval), .commit_pc(c_pc), .commit_seq_num(a_cseq),
    .commit_waddr(c_waddr), .commit_wdata(c_wdata), .commit_wen(c_wen)
  );

  squash_unit_l1_chain #(.p_num_arb(2), .p_seq_num_bits(3)) dut_b (
    .clk(clk), .rst(rst),
    .arb_val(b_val), .arb_seq_num(b_seq), .arb_target(b_tgt),
    .gnt_val(b_gval), .gnt_seq_num(b_gseq), .gnt_target(b_gtgt),
    .commit_val(b_cval), .commit_pc(c_pc), .commit_seq_num(b_cseq),
    .commit_waddr(c_waddr), .commit_wdata(c_wdata), .commit_wen(c_wen)
  );

  squash_unit_l1_chain #(.p_num_arb(20), .p_seq_num_bits(6)) dut_c (
    .clk(clk), .rst(rst),
    .arb_val(c_val), .arb_seq_num(c_seq), .arb_target(c_tgt),
    .gnt_val(c_gval), .gnt_seq_num(c_gseq), .gnt_target(c_gtgt),
    .commit_val(c_cval), .commit_pc(c_pc), .commit_seq_num(c_cseq),
    .commit_waddr(c_waddr), .commit_wdata(c_wdata), .commit_wen(c_wen)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for instance C: commit head plus the current request set.
  int          head_c = 0;
  bit          rv[20];
  int          rs[20];
  logic [31:0] rt[20];

  // Oldest valid request by modular distance from head; first index wins ties. -1 when idle.
  function automatic int ref_winner(int n_arb, int bits, int head);
    int best = -1;
    int best_age = 0;
    int m = 1 << bits;
    for (int i = 0; i < n_arb; i++) begin
      if (rv[i]) begin
        int ag = (((rs[i] - head) % m) + m) % m;
        if (best < 0 || ag < best_age) begin
          best = i;
          best_age = ag;
        end
      end
    end
    return best;
  endfunction

  task automatic commit_a(input int s);
    a_cval = 1'b1; a_cseq = 5'(s);
    @(posedge clk); #1;
    a_cval = 1'b0;
  endtask

  task automatic commit_b(input int s);
    b_cval = 1'b1; b_cseq = 3'(s);
    @(posedge clk); #1;
    b_cval = 1'b0;
  endtask

  task automatic commit_c(input int s);
    c_cval = 1'b1; c_cseq = 6'(s);
    @(posedge clk); #1;
    c_cval = 1'b0;
    head_c = (s + 1) % 64;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int perm[64];
    int w;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("idle_after_reset_val", 64'(a_gval), 64'd0);
    check("idle_after_reset_seq", 64'(a_gseq), 64'd0);
    check("idle_after_reset_tgt", 64'(a_gtgt), 64'd0);

    // Single requester pass-through
    a_val = 4'b0100; a_seq[2] = 5'd7; a_tgt[2] = 32'h1234;
    #1;
    check("pass_val", 64'(a_gval), 64'd1);
    check("pass_seq", 64'(a_gseq), 64'd7);
    check("pass_tgt", 64'(a_gtgt), 64'h1234);
    a_val = '0;

    // Age ordering relative to head = 10
    commit_a(9);
    a_val = 4'b0011;
    a_seq[0] = 5'd12; a_tgt[0] = 32'hA0;
    a_seq[1] = 5'd11; a_tgt[1] = 32'hA1;
    #1;
    check("age_seq11", 64'(a_gseq), 64'd11);
    check("age_tgt11", 64'(a_gtgt), 64'hA1);
    a_seq[1] = 5'd3;
    #1;
    check("age_seq3_younger", 64'(a_gseq), 64'd12);

    // Tie goes to lower index; then idle
    a_seq[0] = 5'd4; a_tgt[0] = 32'hAAAA;
    a_seq[1] = 5'd4; a_tgt[1] = 32'hBBBB;
    #1;
    check("tie_tgt", 64'(a_gtgt), 64'hAAAA);
    a_val = '0;
    #1;
    check("idle_val", 64'(a_gval), 64'd0);
    check("idle_seq", 64'(a_gseq), 64'd0);

    // Reset discards head = 20
    commit_a(19);
    a_val = 4'b0011;
    a_seq[0] = 5'd30; a_tgt[0] = 32'h30;
    a_seq[1] = 5'd1;  a_tgt[1] = 32'h01;
    #1;
    check("pre_reset_seq", 64'(a_gseq), 64'd30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    head_c = 0;
    check("post_reset_seq", 64'(a_gseq), 64'd1);

    // Same-cycle commit: arbitration sees old head until the edge
    a_seq[0] = 5'd0; a_tgt[0] = 32'h100;
    a_seq[1] = 5'd1; a_tgt[1] = 32'h101;
    a_cval = 1'b1; a_cseq = 5'd0;
    #1;
    check("same_cycle_old_head", 64'(a_gseq), 64'd0);
    @(posedge clk); #1;
    a_cval = 1'b0;
    check("after_commit_new_head", 64'(a_gseq), 64'd1);
    a_val = '0;

    // Wrap-around on 3-bit sequence numbers
    commit_b(7);
    b_val = 2'b11;
    b_seq[0] = 3'd5; b_tgt[0] = 32'h55;
    b_seq[1] = 3'd1; b_tgt[1] = 32'h11;
    #1;
    check("wrap_head0_seq", 64'(b_gseq), 64'd1);
    commit_b(4);
    check("wrap_head5_seq", 64'(b_gseq), 64'd5);
    check("wrap_head5_tgt", 64'(b_gtgt), 64'h55);
    b_val = '0;

    // Randomized rounds against the reference model
    for (int r = 0; r < 30; r++) begin
      commit_c(int'($urandom_range(0, 63)));
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 64; i++) perm[i] = i;
        for (int i = 63; i > 0; i--) begin
          int j = int'($urandom_range(0, i));
          int t = perm[i];
          perm[i] = perm[j];
          perm[j] = t;
        end
        for (int i = 0; i < 20; i++) begin
          rv[i] = (k == 2 && r % 5 == 0) ? 1'b0 : bit'($urandom_range(0, 2) == 0);
          rs[i] = perm[i];
          rt[i] = $urandom;
          c_val[i] = rv[i];
          c_seq[i] = 6'(rs[i]);
          c_tgt[i] = rt[i];
        end
        #1;
        w = ref_winner(20, 6, head_c);
        check("rand_val", 64'(c_gval), 64'(w >= 0));
        if (w >= 0) begin
          check("rand_seq", 64'(c_gseq), 64'(rs[w]));
          check("rand_tgt", 64'(c_gtgt), 64'(rt[w]));
        end
        @(posedge clk); #1;
      end
    end
    c_val = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
